// File: rtl/pipelined_control_unit.sv
// MIPS 5-stage pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall FSM and jump/branch flush generation.
package pipelined_control_unit_pkg;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       jal;
    logic [3:0] alu_op;
    logic       branch_eq;
    logic       branch_ne;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
  } id_ex_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ex_mem_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_t;

  localparam id_ex_t CTRL_NOP = '0;

endpackage

module pipelined_control_unit
  import pipelined_control_unit_pkg::*;
#(
  parameter int ALUOP_WIDTH       = 4,
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int HAZARD_EN         = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [5:0]                OP,
  input  logic [5:0]                ALUFunction,
  input  logic [REG_ADDR_WIDTH-1:0] IFID_Rs,
  input  logic [REG_ADDR_WIDTH-1:0] IFID_Rt,
  input  logic                      BranchTaken,
  output logic                      PCWrite,
  output logic                      IFIDWrite,
  output logic                      IFFlush,
  output logic                      Stall,
  output logic                      JR,
  output logic                      Jump,
  output logic                      EX_RegDst,
  output logic                      EX_ALUSrc,
  output logic                      EX_JAL,
  output logic [ALUOP_WIDTH-1:0]    EX_ALUOp,
  output logic                      EX_BranchEQ,
  output logic                      EX_BranchNE,
  output logic                      MEM_MemRead,
  output logic                      MEM_MemWrite,
  output logic                      WB_MemtoReg,
  output logic                      WB_RegWrite
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [3:0] CNT_LOAD =
    4'(LOAD_STALL_CYCLES - 1);
  localparam bit MULTI = (LOAD_STALL_CYCLES > 1);
  localparam bit HZ_ON = (HAZARD_EN != 0);

  state_t  state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  id_ex_t  dec;
  id_ex_t  id_ex;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;
  logic [REG_ADDR_WIDTH-1:0] ex_rt;

  logic is_rtype, is_jr, is_addi, is_andi;
  logic is_ori, is_lui, is_beq, is_bne;
  logic is_lw, is_sw, is_j, is_jal;
  logic jump, jr, load_use, stall_raw;

  assign is_jr    = (OP == 6'h00) && (ALUFunction == 6'h08);
  assign is_rtype = (OP == 6'h00) && !is_jr;
  assign is_addi  = (OP == 6'h08);
  assign is_andi  = (OP == 6'h0C);
  assign is_ori   = (OP == 6'h0D);
  assign is_lui   = (OP == 6'h0F);
  assign is_beq   = (OP == 6'h04);
  assign is_bne   = (OP == 6'h05);
  assign is_lw    = (OP == 6'h23);
  assign is_sw    = (OP == 6'h2B);
  assign is_j     = (OP == 6'h02);
  assign is_jal   = (OP == 6'h03);

  always_comb begin
    dec  = CTRL_NOP;
    jump = 1'b0;
    jr   = 1'b0;
    unique case (1'b1)
      is_rtype: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 4'b0111;
      end
      is_jr: begin
        dec.reg_dst = 1'b1;
        dec.alu_op  = 4'b0111;
        jr          = 1'b1;
      end
      is_addi: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 4'b0100;
      end
      is_andi: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 4'b0110;
      end
      is_ori: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 4'b0101;
      end
      is_lui: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 4'b1000;
      end
      is_beq: begin
        dec.branch_eq = 1'b1;
        dec.alu_op    = 4'b0001;
      end
      is_bne: begin
        dec.branch_ne = 1'b1;
        dec.alu_op    = 4'b0001;
      end
      is_lw: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_op     = 4'b0010;
      end
      is_sw: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_op    = 4'b0011;
      end
      is_j: begin
        jump = 1'b1;
      end
      is_jal: begin
        jump          = 1'b1;
        dec.reg_write = 1'b1;
        dec.jal       = 1'b1;
      end
      default: ;
    endcase
  end

  // $0 is hardwired, so a load targeting it never creates a dependency
  assign load_use = HZ_ON && id_ex.mem_read && (|ex_rt) &&
                    ((ex_rt == IFID_Rs) || (ex_rt == IFID_Rt));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall_raw = 1'b0;
    case (state)
      RUN: begin
        if (load_use) begin
          stall_raw = 1'b1;
          if (MULTI) begin
            state_nxt = STALL;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      STALL: begin
        stall_raw = 1'b1;
        cnt_nxt   = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
    // a taken branch squashes the stalled instruction anyway
    if (BranchTaken) begin
      state_nxt = RUN;
      cnt_nxt   = '0;
      stall_raw = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex  <= CTRL_NOP;
      ex_rt  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      if (BranchTaken || stall_raw) begin
        id_ex <= CTRL_NOP;
        ex_rt <= '0;
      end else begin
        id_ex <= dec;
        ex_rt <= IFID_Rt;
      end
      ex_mem <= '{mem_read:   id_ex.mem_read,
                  mem_write:  id_ex.mem_write,
                  mem_to_reg: id_ex.mem_to_reg,
                  reg_write:  id_ex.reg_write};
      mem_wb <= '{mem_to_reg: ex_mem.mem_to_reg,
                  reg_write:  ex_mem.reg_write};
    end
  end

  assign Stall     = stall_raw;
  assign PCWrite   = !stall_raw;
  assign IFIDWrite = !stall_raw;
  assign IFFlush   = reset &&
                     (BranchTaken || (!stall_raw && (jump || jr)));
  assign JR        = jr;
  assign Jump      = jump;

  assign EX_RegDst    = id_ex.reg_dst;
  assign EX_ALUSrc    = id_ex.alu_src;
  assign EX_JAL       = id_ex.jal;
  assign EX_ALUOp     = ALUOP_WIDTH'(id_ex.alu_op);
  assign EX_BranchEQ  = id_ex.branch_eq;
  assign EX_BranchNE  = id_ex.branch_ne;
  assign MEM_MemRead  = ex_mem.mem_read;
  assign MEM_MemWrite = ex_mem.mem_write;
  assign WB_MemtoReg  = mem_wb.mem_to_reg;
  assign WB_RegWrite  = mem_wb.reg_write;

endmodule
